// File: rtl/fifo_pkg.sv
// Shared types and default widths for the async FIFO and its write-side producer.
package fifo_pkg;
  localparam int FIFO_DATASIZE = 8;
  localparam int FIFO_LENW     = 8;

  typedef enum logic [1:0] {WR_IDLE, WR_SEND, WR_DONE} wr_state_t;
endpackage

// File: rtl/fifo_burst_writer_if.sv
// Burst control plus FIFO write-port bundle between the burst writer and its environment.
interface fifo_burst_writer_if
  import fifo_pkg::*;
#(
  parameter int DATASIZE = FIFO_DATASIZE,
  parameter int LENW     = FIFO_LENW
);
  logic                start;
  logic [LENW-1:0]     burst_len;
  logic [DATASIZE-1:0] seed;
  logic                busy;
  logic                done;
  logic [LENW-1:0]     words_written;
  logic                winc;
  logic [DATASIZE-1:0] wdata;
  logic                wfull;
  logic                walmost_full;

  modport master (
    input  start, burst_len, seed, wfull, walmost_full,
    output busy, done, words_written, winc, wdata
  );
  modport slave (
    output start, burst_len, seed, wfull, walmost_full,
    input  busy, done, words_written, winc, wdata
  );
endinterface

// File: rtl/fifo_wr_datagen.sv
// Write-data generator: seed load, increment on accept, and (FIFO_WR_CHECKSUM_EN)
// an XOR accumulator that replaces the next word with the burst checksum.
module fifo_wr_datagen
  import fifo_pkg::*;
#(
  parameter int DATASIZE = FIFO_DATASIZE
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                i_load,
  input  logic [DATASIZE-1:0] i_seed,
  input  logic                i_accept,
`ifdef FIFO_WR_CHECKSUM_EN
  input  logic                i_last,
`endif
  output logic [DATASIZE-1:0] o_data
);
  logic [DATASIZE-1:0] r_data;

`ifdef FIFO_WR_CHECKSUM_EN
  logic [DATASIZE-1:0] r_acc;

  // After the last data word, the checksum (running XOR plus that word) becomes the next word.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_data <= '0;
      r_acc  <= '0;
    end else if (i_load) begin
      r_data <= i_seed;
      r_acc  <= '0;
    end else if (i_accept) begin
      r_acc  <= r_acc ^ r_data;
      r_data <= i_last ? (r_acc ^ r_data) : r_data + 1'b1;
    end
  end
`else
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n)       r_data <= '0;
    else if (i_load)   r_data <= i_seed;
    else if (i_accept) r_data <= r_data + 1'b1;
  end
`endif

  assign o_data = r_data;
endmodule

// File: rtl/fifo_burst_writer.sv
// Burst producer for the async FIFO write port: BURST_LEN incrementing words from a seed,
// stalling on wfull. Define FIFO_WR_CHECKSUM_EN to append an XOR checksum word.
module fifo_burst_writer
  import fifo_pkg::*;
#(
  parameter int DATASIZE = FIFO_DATASIZE,
  parameter int LENW     = FIFO_LENW,
  parameter int AF_GAP   = 0
) (
  input  logic                wclk,
  input  logic                wrst_n,
  fifo_burst_writer_if.master bus
);
  wr_state_t       r_state;
  logic            r_busy;
  logic            r_done;
  logic            r_gap;
  logic [LENW-1:0] r_cnt;
  logic [LENW-1:0] r_len;

  logic w_winc;
  logic w_zero;
  logic w_last_data;
  logic w_last;

  assign w_zero = (bus.burst_len == '0);
  assign w_winc = (r_state == WR_SEND) && !bus.wfull && !r_gap;

`ifdef FIFO_WR_CHECKSUM_EN
  logic r_csum;
  assign w_last_data = (r_state == WR_SEND) && !r_csum && (r_cnt == LENW'(r_len - 1'b1));
  assign w_last      = r_csum;
`else
  assign w_last_data = (r_state == WR_SEND) && (r_cnt == LENW'(r_len - 1'b1));
  assign w_last      = w_last_data;
`endif

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state <= WR_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_gap   <= 1'b0;
      r_cnt   <= '0;
      r_len   <= '0;
`ifdef FIFO_WR_CHECKSUM_EN
      r_csum  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        WR_IDLE: if (bus.start) begin
          r_len  <= bus.burst_len;
          r_cnt  <= '0;
          r_busy <= 1'b1;
          r_gap  <= 1'b0;
`ifdef FIFO_WR_CHECKSUM_EN
          r_csum <= 1'b0;
`endif
          if (w_zero) begin
            r_state <= WR_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= WR_SEND;
          end
        end
        WR_SEND: begin
          // Gap holds off exactly one cycle after each write made while almost full.
          r_gap <= (AF_GAP != 0) && w_winc && bus.walmost_full;
          if (w_winc) begin
            r_cnt <= r_cnt + 1'b1;
`ifdef FIFO_WR_CHECKSUM_EN
            if (w_last_data) r_csum <= 1'b1;
`endif
            if (w_last) begin
              r_state <= WR_DONE;
              r_done  <= 1'b1;
              r_gap   <= 1'b0;
            end
          end
        end
        WR_DONE: begin
          r_state <= WR_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= WR_IDLE;
      endcase
    end
  end

  fifo_wr_datagen #(.DATASIZE(DATASIZE)) u_datagen (
    .wclk    (wclk),
    .wrst_n  (wrst_n),
    .i_load  ((r_state == WR_IDLE) && bus.start && !w_zero),
    .i_seed  (bus.seed),
    .i_accept(w_winc),
`ifdef FIFO_WR_CHECKSUM_EN
    .i_last  (w_last_data),
`endif
    .o_data  (bus.wdata)
  );

  assign bus.winc          = w_winc;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.words_written = r_cnt;
endmodule

// File: tb/tb_fifo_burst_writer.sv
// Bench for fifo_burst_writer: a 16-deep FIFO model with a scoreboard of expected words,
// a vector table of bursts, and hand sequences for full, len=0, start spam, reset and AF gap.
module tb_fifo_burst_writer;
  import fifo_pkg::*;
  localparam int DW = 8;
  localparam int LW = 8;
`ifdef FIFO_WR_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic wclk = 1'b0;
  logic wrst_n = 1'b0;
  always #5 wclk = ~wclk;

  fifo_burst_writer_if #(.DATASIZE(DW), .LENW(LW)) bus ();
  fifo_burst_writer_if #(.DATASIZE(DW), .LENW(LW)) bus2 ();

  fifo_burst_writer #(.DATASIZE(DW), .LENW(LW), .AF_GAP(0)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .bus(bus)
  );
  fifo_burst_writer #(.DATASIZE(DW), .LENW(LW), .AF_GAP(1)) dut_gap (
    .wclk(wclk), .wrst_n(wrst_n), .bus(bus2)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  logic rinc = 1'b0;
  int n_wr, n_done, n_wr2, viol2;
  logic prev2 = 1'b0;

  typedef struct {
    int        len;
    logic [7:0] seed;
    int        ww;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample at negedge, model FIFO/reader at posedge+1, return at next negedge.
  task automatic step();
    logic acc, rd, dn, a2;
    logic [DW-1:0] d, g;
    acc = wrst_n && bus.winc;
    d   = bus.wdata;
    rd  = rinc && (fq.size() > 0);
    dn  = wrst_n && bus.done;
    a2  = wrst_n && bus2.winc;
    @(posedge wclk);
    #1;
    if (rd) begin
      g = fq.pop_front();
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_read: got %0h expected none", g);
      end else begin
        chk("rdata", g, exp_q.pop_front());
      end
    end
    if (acc) begin
      chk("no_overflow", fq.size() < 16, 1);
      fq.push_back(d);
      n_wr++;
    end
    if (dn) n_done++;
    if (a2) begin
      n_wr2++;
      if (prev2) viol2++;
    end
    prev2 = a2;
    bus.wfull        = (fq.size() >= 16);
    bus.walmost_full = (fq.size() >= 12);
    @(negedge wclk);
  endtask

  task automatic push_exp(input int len, input logic [7:0] seed);
    logic [7:0] x, v;
    x = '0; v = seed;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(v);
      x = x ^ v;
      v = v + 8'd1;
    end
    if (CS != 0 && len != 0) exp_q.push_back(x);
  endtask

  task automatic go(input int len, input logic [7:0] seed);
    bus.start = 1'b1; bus.burst_len = LW'(len); bus.seed = seed;
    push_exp(len, seed);
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int maxc);
    int c;
    c = 0;
    while (!bus.done && c < maxc) begin step(); c++; end
    if (!bus.done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no done expected done within %0d cycles", name, maxc);
    end
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    rinc = 1'b1;
    while ((fq.size() > 0 || exp_q.size() > 0) && c < 200) begin step(); c++; end
    chk({name, "_exp_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int c;
    vecs[0] = '{5,  8'hFD, 5 + CS};
    vecs[1] = '{1,  8'h00, 1 + CS};
    vecs[2] = '{3,  8'h7F, 3 + CS};
    vecs[3] = '{12, 8'hF8, 12 + CS};

    bus.start = 1'b0; bus.burst_len = '0; bus.seed = '0;
    bus.wfull = 1'b0; bus.walmost_full = 1'b0;
    bus2.start = 1'b0; bus2.burst_len = '0; bus2.seed = '0;
    bus2.wfull = 1'b0; bus2.walmost_full = 1'b0;
    repeat (2) @(negedge wclk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ww", bus.words_written, 0);
    chk("rst_winc", bus.winc, 0);
    chk("rst_wdata", bus.wdata, 0);
    wrst_n = 1'b1;
    step();

    // Table: reader always on
    rinc = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_wr = 0; n_done = 0;
      go(vecs[i].len, vecs[i].seed);
      chk("first_winc", bus.winc, 1);
      chk("first_wdata", bus.wdata, vecs[i].seed);
      wait_done("vec", 100);
      chk("vec_busy_in_done", bus.busy, 1);
      step();
      chk("vec_done_pulse", bus.done, 0);
      chk("vec_busy_idle", bus.busy, 0);
      chk("vec_ww", bus.words_written, vecs[i].ww);
      chk("vec_nwr", n_wr, vecs[i].ww);
      drain("vec");
      chk("vec_ndone", n_done, 1);
    end

    // Full FIFO with reader stalled, then resume
    rinc = 1'b0; n_wr = 0; n_done = 0;
    go(20, 8'h00);
    repeat (16) step();
    chk("full_count", fq.size(), 16);
    repeat (4) step();
    chk("full_winc", bus.winc, 0);
    chk("full_busy", bus.busy, 1);
    chk("full_ww", bus.words_written, 16);
    chk("full_wdata_hold", bus.wdata, 8'h10);
    rinc = 1'b1;
    wait_done("full", 100);
    chk("full_ww_final", bus.words_written, 20 + CS);
    drain("full");
    chk("full_ndone", n_done, 1);

    // len = 0
    n_wr = 0; n_done = 0;
    go(0, 8'h55);
    chk("z_done", bus.done, 1);
    chk("z_busy", bus.busy, 1);
    chk("z_winc", bus.winc, 0);
    step();
    chk("z_done_off", bus.done, 0);
    chk("z_busy_off", bus.busy, 0);
    chk("z_ww", bus.words_written, 0);
    chk("z_nwr", n_wr, 0);

    // start held every cycle through a len=8 burst
    n_wr = 0; n_done = 0;
    bus.start = 1'b1; bus.burst_len = 8'd8; bus.seed = 8'h30;
    push_exp(8, 8'h30);
    step();
    c = 0;
    while (!bus.done && c < 100) begin step(); c++; end
    step();
    bus.start = 1'b0;
    repeat (3) step();
    chk("spam_nwr", n_wr, 8 + CS);
    chk("spam_busy", bus.busy, 0);
    drain("spam");
    chk("spam_ndone", n_done, 1);
    n_wr = 0;
    go(2, 8'h20);
    wait_done("spam2", 50);
    drain("spam2");
    chk("spam2_nwr", n_wr, 2 + CS);

    // Reset mid-burst
    n_wr = 0;
    go(10, 8'h10);
    c = 0;
    while (n_wr < 3 && c < 50) begin step(); c++; end
    wrst_n = 1'b0;
    #1;
    chk("mrst_winc", bus.winc, 0);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_done", bus.done, 0);
    chk("mrst_ww", bus.words_written, 0);
    chk("mrst_wdata", bus.wdata, 0);
    fq.delete(); exp_q.delete();
    bus.wfull = 1'b0; bus.walmost_full = 1'b0;
    step(); step();
    wrst_n = 1'b1;
    step();
    n_wr = 0;
    go(2, 8'h40);
    wait_done("mrst", 50);
    drain("mrst");
    chk("mrst_nwr", n_wr, 2 + CS);

    // AF_GAP instance: almost full held high, then low
    bus2.walmost_full = 1'b1; n_wr2 = 0; viol2 = 0;
    bus2.start = 1'b1; bus2.burst_len = 8'd6; bus2.seed = 8'h00;
    step();
    bus2.start = 1'b0;
    c = 0;
    while (!bus2.done && c < 100) begin step(); c++; end
    step();
    chk("gap_viol", viol2, 0);
    chk("gap_nwr", n_wr2, 6 + CS);
    chk("gap_ww", bus2.words_written, 6 + CS);
    bus2.walmost_full = 1'b0; n_wr2 = 0; viol2 = 0;
    bus2.start = 1'b1; bus2.burst_len = 8'd4; bus2.seed = 8'h80;
    step();
    bus2.start = 1'b0;
    c = 0;
    while (!bus2.done && c < 100) begin step(); c++; end
    step();
    chk("nogap_b2b", viol2, 3 + CS);
    chk("nogap_nwr", n_wr2, 4 + CS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
